conv_encoder: RTL and testbench

- Rate-1/2, constraint-length-4 (8-state) convolutional encoder with zero-tail frame termination.
- Transmit-side counterpart of the Viterbi decoder: produces the 2-bit code symbols that the decoder's BMU/ACS/traceback chain consumes.
- Valid/ready streaming on both sides. Each frame ends in the all-zero state, so traceback can start from state 0.

---
 rtl/viterbi_pkg.sv | 9 +
 rtl/conv_enc_core.sv | 17 +
 rtl/conv_encoder.sv | 80 ++++++++
 tb/tb_conv_encoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and encoder FSM type for the convolutional encoder / Viterbi decoder pair
package viterbi_pkg;
  localparam int STATE_W = 3;
  localparam int NUM_STATES = 8;
  localparam int TAIL_LEN = 3;
  localparam logic [3:0] G0 = 4'b1101;
  localparam logic [3:0] G1 = 4'b1111;
  typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational rate-1/2 K=4 encoder step
//   reg4    : {b, sr[2:0]}, b = current input bit
//   code    : {c1, c0} code symbol
//   sr_next : shift register after shifting b in at the top
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [3:0] G0_P = G0,
  parameter logic [3:0] G1_P = G1
) (
  input  logic [3:0]         reg4,
  output logic [1:0]         code,
  output logic [STATE_W-1:0] sr_next
);
  assign code = {^(G1_P & reg4), ^(G0_P & reg4)};
  assign sr_next = reg4[3:1];
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=4 convolutional encoder with zero-tail termination and valid/ready streaming
//   clk, rst (async active-low), enable (sync clear when low)
//   din/din_valid/din_last/din_ready : information bit stream
//   enc_out/enc_valid/enc_last/enc_keep/enc_ready : code symbol stream, enc_out = {c1, c0}
//   CONV_ENC_PUNCT_EN : rate-2/3 puncturing via enc_keep; otherwise enc_keep = 2'b11
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter logic [3:0] G0_P = G0,
  parameter logic [3:0] G1_P = G1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic [1:0] enc_out,
  output logic       enc_valid,
  output logic       enc_last,
  output logic [1:0] enc_keep,
  input  logic       enc_ready
);
  localparam logic [1:0] LAST_CNT = 2'(TAIL_LEN - 1);
  enc_state_t state, state_next;
  logic [STATE_W-1:0] sr, sr_next;
  logic [1:0] tail_cnt, code;
  logic slot_free, accept, tail_go, load, tail_end, b;
  conv_enc_core #(.G0_P(G0_P), .G1_P(G1_P)) core (
    .reg4(4'({b, sr})),
    .code(code),
    .sr_next(sr_next)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_next;
  always_comb
    state_next = !enable ? IDLE : accept ? (din_last ? TAIL : DATA) : tail_end ? IDLE : state;
  always_comb begin
    slot_free = !enc_valid || enc_ready;
    din_ready = enable && state != TAIL && slot_free;
    accept = din_valid && din_ready;
    tail_go = enable && state == TAIL && slot_free;
    load = accept || tail_go;
    tail_end = tail_go && tail_cnt == LAST_CNT;
    b = state != TAIL && din;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst || !enable) begin
      sr <= '0;
      tail_cnt <= '0;
      enc_out <= '0;
      enc_valid <= 1'b0;
      enc_last <= 1'b0;
    end else if (load) begin
      sr <= sr_next;
      tail_cnt <= tail_go && !tail_end ? tail_cnt + 2'd1 : 2'd0;
      enc_out <= code;
      enc_valid <= 1'b1;
      enc_last <= tail_end;
    end else if (enc_ready) begin
      enc_valid <= 1'b0;
      enc_last <= 1'b0;
    end
`ifdef CONV_ENC_PUNCT_EN
  logic punct_idx;
  // puncturing phase restarts with every frame so the decoder can align on frame start
  always_ff @(posedge clk or negedge rst)
    if (!rst || !enable) begin
      punct_idx <= 1'b0;
      enc_keep <= 2'b11;
    end else if (load) begin
      enc_keep <= punct_idx ? 2'b01 : 2'b11;
      punct_idx <= !tail_end && !punct_idx;
    end
`else
  assign enc_keep = 2'b11;
`endif
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: randomized self-checking bench for conv_encoder against a frame-level reference model
module tb_conv_encoder;
  import viterbi_pkg::*;
  logic clk = 1'b0, rst, enable, din, din_valid, din_last, enc_ready;
  logic din_ready, enc_valid, enc_last;
  logic [1:0] enc_out, enc_keep;
  int total = 0, bad = 0;
  logic [4:0] got[$];
  bit acc, last_hs, rdy_s;
  conv_encoder dut (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .din_valid(din_valid),
    .din_last(din_last), .din_ready(din_ready), .enc_out(enc_out), .enc_valid(enc_valid),
    .enc_last(enc_last), .enc_keep(enc_keep), .enc_ready(enc_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // samples the stream just before the next edge, then advances one clock
  task automatic cyc();
    #1;
    acc = din_valid && din_ready;
    rdy_s = din_ready;
    last_hs = enc_valid && enc_ready && enc_last;
    if (enc_valid && enc_ready) got.push_back({enc_last, enc_keep, enc_out});
    @(posedge clk);
    #1;
  endtask
  // frame-level reference: the 3-bit history is an integer, each symbol is the parity of tapped bits
  function automatic void model(input bit bits[$], output logic [4:0] exp[$]);
    int s, r, n;
    bit c0, c1, bt;
    logic [1:0] k;
    exp.delete();
    s = 0;
    n = bits.size();
    for (int i = 0; i < n + 3; i++) begin
      bt = i < n ? bits[i] : 1'b0;
      r = (bt ? 8 : 0) + s;
      c0 = $countones(r & 'b1101) % 2 == 1;
      c1 = $countones(r & 'b1111) % 2 == 1;
      s = r / 2;
`ifdef CONV_ENC_PUNCT_EN
      k = i % 2 == 1 ? 2'b01 : 2'b11;
`else
      k = 2'b11;
`endif
      exp.push_back({i == n + 2, k, c1, c0});
    end
  endfunction
  function automatic void rand_bits(input int n, output bit q[$]);
    q.delete();
    repeat (n) q.push_back(1'($urandom));
  endfunction
  task automatic cmp_frame(input string tag, input bit bits[$]);
    logic [4:0] exp[$];
    model(bits, exp);
    chk({tag, " count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s sym%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask
  task automatic send_frame(input bit bits[$], input bit rnd, input int stall_at, output int zero);
    int idx, cycles, pre;
    bit done, stalled;
    logic [1:0] cap;
    got.delete();
    idx = 0; cycles = 0; done = 0; stalled = 0; zero = 0;
    while (!done && cycles < 500) begin
      if (idx == stall_at && !stalled) begin
        stalled = 1;
        cap = enc_out;
        enc_ready = 1'b0;
        din_valid = 1'b1;
        din = bits[idx];
        din_last = idx == bits.size() - 1;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1;
          chk("stall enc_valid", 32'(enc_valid), 32'd1);
          chk("stall enc_out", 32'(enc_out), 32'(cap));
          chk("stall din_ready", 32'(din_ready), 32'd0);
        end
      end
      enc_ready = rnd ? $urandom_range(3) != 0 : 1'b1;
      if (idx < bits.size()) begin
        din_valid = rnd ? $urandom_range(2) != 0 : 1'b1;
        din = bits[idx];
        din_last = idx == bits.size() - 1;
      end else begin
        din_valid = 1'b0;
        din = 1'($urandom);
        din_last = 1'b0;
      end
      pre = idx;
      cyc();
      if (acc) idx++;
      if (pre == bits.size() && !rdy_s) zero++;
      done = last_hs;
      cycles++;
    end
    chk("frame done", 32'(done), 32'd1);
    enc_ready = 1'b1;
  endtask
  initial begin
    bit q[$];
    int z, nl;
    logic [1:0] sgl[4];
    logic [1:0] skeep[4];
    sgl = '{2'b11, 2'b11, 2'b10, 2'b11};
`ifdef CONV_ENC_PUNCT_EN
    skeep = '{2'b11, 2'b01, 2'b11, 2'b01};
`else
    skeep = '{2'b11, 2'b11, 2'b11, 2'b11};
`endif
    rst = 1'b0; enable = 1'b1; din = 1'b0; din_valid = 1'b0; din_last = 1'b0; enc_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset enc_valid", 32'(enc_valid), 32'd0);
    chk("reset enc_out", 32'(enc_out), 32'd0);
    chk("reset enc_last", 32'(enc_last), 32'd0);
    chk("reset enc_keep", 32'(enc_keep), 32'd3);
    chk("reset sr", 32'(dut.sr), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q = '{1'b1};
    send_frame(q, 0, -1, z);
    cmp_frame("single", q);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk($sformatf("single out%0d", i), 32'(got[i][1:0]), 32'(sgl[i]));
      chk($sformatf("single keep%0d", i), 32'(got[i][3:2]), 32'(skeep[i]));
      chk($sformatf("single last%0d", i), 32'(got[i][4]), 32'(i == 3));
    end
    chk("single end sr", 32'(dut.sr), 32'd0);
    chk("single end state", 32'(dut.state), 32'(IDLE));
    q = '{1'b1, 1'b0, 1'b1, 1'b1};
    send_frame(q, 0, -1, z);
    cmp_frame("f1011", q);
    chk("f1011 tail din_ready low", 32'(z), 32'd3);
    for (int f = 0; f < 6; f++) begin
      rand_bits($urandom_range(1, 12), q);
      send_frame(q, 1, -1, z);
      cmp_frame($sformatf("rand%0d", f), q);
    end
    rand_bits(8, q);
    send_frame(q, 0, 3, z);
    cmp_frame("backpressure", q);
    got.delete();
    din_valid = 1'b1; din = 1'b1; din_last = 1'b0;
    cyc();
    din_last = 1'b1;
    cyc();
    din_valid = 1'b0; din_last = 1'b0;
    cyc();
    chk("tail1 enc_valid", 32'(enc_valid), 32'd1);
    chk("tail1 state", 32'(dut.state), 32'(TAIL));
    enable = 1'b0;
    cyc();
    chk("disable enc_valid", 32'(enc_valid), 32'd0);
    chk("disable enc_last", 32'(enc_last), 32'd0);
    chk("disable state", 32'(dut.state), 32'(IDLE));
    chk("disable sr", 32'(dut.sr), 32'd0);
    nl = 0;
    foreach (got[i]) if (got[i][4]) nl++;
    chk("disable no enc_last", 32'(nl), 32'd0);
    enable = 1'b1;
    rand_bits(5, q);
    send_frame(q, 1, -1, z);
    cmp_frame("after disable", q);
    got.delete();
    din_valid = 1'b1; din = 1'b1; din_last = 1'b0;
    cyc();
    din = 1'b0;
    cyc();
    din_valid = 1'b0;
    chk("pre-reset state", 32'(dut.state), 32'(DATA));
    chk("pre-reset enc_valid", 32'(enc_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async enc_valid", 32'(enc_valid), 32'd0);
    chk("async enc_out", 32'(enc_out), 32'd0);
    chk("async enc_last", 32'(enc_last), 32'd0);
    chk("async enc_keep", 32'(enc_keep), 32'd3);
    chk("async sr", 32'(dut.sr), 32'd0);
    chk("async state", 32'(dut.state), 32'(IDLE));
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rand_bits(6, q);
    send_frame(q, 1, -1, z);
    cmp_frame("after reset", q);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
